// File: rtl/reg_scan_reader.sv
// Sequential register-file dump engine: walks rd_addr over every register and streams each value out over valid/ready.
// Optional running checksum of emitted words when REG_SCAN_CHECKSUM_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; done pulses here for one cycle after a scan
// CAPTURE | rd_data for rd_addr is latched into the output word
// SEND    | word held on out_*, waiting for out_ready
module reg_scan_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data
`ifdef REG_SCAN_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  if (NUM_REGS > (2 ** ADDR_W)) begin : g_bad_params
    $error("reg_scan_reader: NUM_REGS exceeds 2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SEND
  } state_e;

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                out_valid_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   out_index_q;
  logic [DATA_W-1:0]   out_data_q;

  logic start_accept;
  logic handshake;

  // done_q marks the first IDLE cycle, during which a new start is still ignored.
  assign start_accept = (state_q == ST_IDLE) && start && !done_q;
  assign handshake    = (state_q == ST_SEND) && out_valid_q && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      rd_addr_q   <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_accept) begin
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          out_data_q  <= rd_data;
          out_index_q <= rd_addr_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (handshake) begin
            out_valid_q <= 1'b0;
            if (out_index_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              rd_addr_q <= rd_addr_q + 1'b1;
              state_q   <= ST_CAPTURE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef REG_SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= '0;
    end else if (start_accept) begin
      checksum_q <= '0;
    end else if (handshake) begin
      checksum_q <= checksum_q + out_data_q;
    end
  end

  assign checksum = checksum_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_reg_scan_reader.sv
// Bench for reg_scan_reader: a table of scan scenarios against a register-file array model, plus a mid-scan reset sequence.
module tb_reg_scan_reader;
  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [31:0] out_data;
`ifdef REG_SCAN_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] regs [NR];

  reg_scan_reader #(.NUM_REGS(NR), .ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_data  (out_data)
`ifdef REG_SCAN_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  always_comb rd_data = regs[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          stall;
    bit          rnd_ready;
    int          start_at;
    bit          start_on_done;
    int          wr_at;
    int          wr_idx;
    logic [31:0] wr_data;
    int          exp_lat;
    bit          rnd_data;
  } vec_t;

  vec_t vecs [6];

  task automatic preload(input bit rnd);
    for (int i = 0; i < NR; i++) regs[i] = rnd ? $urandom : (32'h100 + 32'(i));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
  endtask

  // Drives one full scan from the start pulse to a few cycles past done.
  task automatic run_scan(input vec_t v, input string tag);
    int          word_k = 0;
    int          done_cnt = 0;
    int          post = 0;
    int          stall_left = 0;
    int          s_cyc;
    int          first_v = -1;
    int          done_cyc = -1;
    bit          in_word = 0;
    bit          held = 0;
    bit          seen_done = 0;
    bit          timed_out = 1;
    bit          wrote = 0;
    bit          pulsed = 0;
    logic [31:0] held_d = '0;
    logic [4:0]  held_i = '0;
    logic [31:0] sum = '0;

    preload(v.rnd_data);
    @(negedge clk);
    start = 1'b1;
    out_ready = (v.stall == 0 && !v.rnd_ready);
    @(negedge clk);
    s_cyc = cyc;
    check({tag, "_busy_after_start"}, {31'b0, busy}, 32'd1);
    for (int t = 0; t < 4000; t++) begin
      start = 1'b0;
      if (out_valid && first_v < 0) first_v = cyc - s_cyc;
      if (held) begin
        check({tag, "_stall_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_stall_index"}, {27'b0, out_index}, {27'b0, held_i});
        check({tag, "_stall_data"}, out_data, held_d);
        held = 0;
      end
      if (done) begin
        done_cnt++;
        if (!seen_done) begin
          seen_done = 1;
          done_cyc = cyc - s_cyc;
`ifdef REG_SCAN_CHECKSUM_EN
          check({tag, "_checksum"}, checksum, sum);
`endif
          if (v.start_on_done) start = 1'b1;
        end
      end
      if (v.wr_at >= 0 && !wrote && word_k == v.wr_at) begin
        regs[v.wr_idx] = v.wr_data;
        wrote = 1;
      end
      if (v.start_at >= 0 && !pulsed && word_k == v.start_at) begin
        start = 1'b1;
        pulsed = 1;
      end
      if (out_valid) begin
        if (!in_word) begin
          in_word = 1;
          stall_left = v.rnd_ready ? int'($urandom_range(0, 3)) : v.stall;
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          held = 1;
          held_d = out_data;
          held_i = out_index;
        end else begin
          out_ready = 1'b1;
          if (word_k < NR) begin
            check({tag, "_index"}, {27'b0, out_index}, 32'(word_k));
            check({tag, "_data"}, out_data, regs[word_k]);
            sum = sum + regs[word_k];
          end else begin
            check({tag, "_extra_word"}, 32'(word_k), 32'(NR - 1));
          end
          word_k++;
          in_word = 0;
        end
      end else begin
        out_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : (v.stall == 0);
      end
      if (seen_done) begin
        post++;
        if (post > 4) begin
          timed_out = 0;
          break;
        end
      end
      @(negedge clk);
    end
    check({tag, "_timeout"}, {31'b0, timed_out}, 32'd0);
    check({tag, "_word_count"}, 32'(word_k), 32'(NR));
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_first_valid_lat"}, 32'(first_v), 32'd1);
    if (v.exp_lat > 0) check({tag, "_done_lat"}, 32'(done_cyc), 32'(v.exp_lat));
    if (v.wr_at >= 0) check({tag, "_written_reg"}, regs[v.wr_idx], v.wr_data);
    check_idle_outputs({tag, "_post"});
`ifdef REG_SCAN_CHECKSUM_EN
    check({tag, "_checksum_hold"}, checksum, sum);
`endif
    out_ready = 1'b0;
  endtask

  initial begin
    bit found;
    //           stall rnd st_at on_done wr_at wr_idx wr_data       lat rnd_data
    vecs[0] = '{0,     0,  -1,   0,      -1,   0,     32'h0,        64, 0};
    vecs[1] = '{5,     0,  -1,   0,      -1,   0,     32'h0,        0,  0};
    vecs[2] = '{0,     0,  10,   1,      -1,   0,     32'h0,        64, 0};
    vecs[3] = '{0,     0,  -1,   0,      5,    20,    32'hDEADBEEF, 64, 0};
    vecs[4] = '{0,     1,  -1,   0,      -1,   0,     32'h0,        0,  1};
    vecs[5] = '{2,     0,  31,   1,      -1,   0,     32'h0,        0,  1};

    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    preload(0);
    #12;
    check_idle_outputs("reset");
    check("reset_rd_addr", {27'b0, rd_addr}, 32'd0);
    check("reset_out_index", {27'b0, out_index}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
`ifdef REG_SCAN_CHECKSUM_EN
    check("reset_checksum", checksum, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_scan(vecs[i], $sformatf("vec%0d", i));

    // Abort during word 7's SEND, then restart cleanly.
    preload(0);
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int t = 0; t < 400; t++) begin
      if (out_valid && out_index == 5'd7) begin
        found = 1;
        break;
      end
      out_ready = out_valid;
      @(negedge clk);
    end
    check("abort_reached_word7", {31'b0, found}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    check("abort_rd_addr", {27'b0, rd_addr}, 32'd0);
`ifdef REG_SCAN_CHECKSUM_EN
    check("abort_checksum", checksum, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check_idle_outputs("abort_quiet");
    end
    run_scan(vecs[0], "restart");
    run_scan(vecs[0], "repeat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
